jesd204b_link_ctrl: RTL and testbench
=====================================

# jesd204b_link_ctrl

JESD204B subclass-1 receive link controller for the 4-lane GTY receive path. It sequences link bring-up from the transceiver reset-done indication through code-group synchronization (CGS), initial lane alignment sequence (ILAS) and user data. While in CGS it drives the comma-align enables and the active-low SYNC~ request to the ADC. In DATA it forwards lane words with a valid flag and error accounting, and it forces a resync when error or transmitter conditions require one.

## Interface
- LANES, 4, number of lanes (32-bit user word each)
- CGS_COUNT, 4, consecutive all-K28.5 words required per lane for lock
- ILAS_MF, 4, ILAS multiframes (/A/ characters) per lane
- ILAS_TIMEOUT, 1024, max cycles allowed in ILAS
- ERR_THRESH, 8, consecutive error cycles in DATA that force resync

- i_clk  in  1  rx user clock (rxusrclk2 domain); all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_gt_rx_done  in  1  transceiver rx reset done
- i_byteisaligned  in  LANES  per-lane comma byte alignment
- i_rx_data  in  32*LANES  lane words; lane n at [32n+31:32n], octet 0 at [7:0]
- i_rx_k  in  4*LANES  per-octet K-flag
- i_rx_err  in  4*LANES  per-octet disparity/not-in-table error
- o_nsync  out  1  SYNC~ to ADC, low = sync request
- o_commaalignen  out  LANES  drives both p/m comma-align enables
- o_state  out  2  0 WAIT, 1 CGS, 2 ILAS, 3 DATA
- o_lane_locked  out  LANES  per-lane CGS lock
- o_data  out  32*LANES  registered lane data
- o_data_valid  out  1  o_data valid
- o_err_cnt  out  8  saturating DATA-state error-cycle count

## Operation
- Reset values: o_state=WAIT, o_nsync=0, o_commaalignen=0, o_lane_locked=0, o_data=0, o_data_valid=0, o_err_cnt=0, and all internal counters 0.
- Highest priority: i_gt_rx_done=0 in any state sends the FSM to WAIT on the next cycle and clears lane counters. o_err_cnt is retained.
- WAIT: o_nsync=0 and o_commaalignen=0. The FSM goes to CGS when i_gt_rx_done=1.
- CGS: o_nsync=0 and o_commaalignen all 1.
  - A "K word" is data 0xBCBCBCBC with K=4'hF, err=0 and byteisaligned=1.
  - Each lane counter increments on a K word, saturates at CGS_COUNT, and resets to 0 on any other word.
  - o_lane_locked[n] = (counter n == CGS_COUNT).
  - All lanes locked: the FSM goes to ILAS and o_nsync rises in the same cycle o_state becomes ILAS.
- ILAS: o_nsync=1, o_commaalignen=0 (alignment frozen). Per lane:
  - Before /R/, a K word is accepted.
  - /R/ start is octet 0 = K28.0 (0x1C, K=1).
  - Any other word before /R/, or /R/ at octet 1..3, is an error.
  - After /R/, the lane counts /A/ = octet 3 = K28.3 (0x7C, K=1). The ILAS_MF-th /A/ marks the lane done.
- ILAS exits:
  - All lanes done in the same cycle: DATA next cycle.
  - Lanes done in different cycles (no deskew in this block), any ILAS error, or ILAS_TIMEOUT cycles elapsed: CGS next cycle, o_nsync=0.
- DATA:
  - o_data <= i_rx_data and o_data_valid=1, starting the cycle after entry.
  - An error cycle is any lane with nonzero i_rx_err or byteisaligned=0. It increments o_err_cnt (saturating at 255) and the consecutive-error counter. A clean cycle clears the consecutive counter.
  - Consecutive counter reaching ERR_THRESH: CGS next cycle.
  - A K word on any lane (transmitter resync): CGS next cycle.
  - On leaving DATA, o_data_valid=0 from the next cycle. o_data holds its last value.

## Timing
- o_nsync, o_commaalignen and o_data_valid are registered, decoded from the next state, and change in the same cycle as o_state.
- CGS lock: the FSM reaches ILAS at the earliest CGS_COUNT+1 cycles after the first K word on the last lane.
- DATA latency: i_rx_data to o_data is 1 cycle.
- Simultaneous events in DATA: i_gt_rx_done=0 beats resync, and resync beats the error counter. The ERR_THRESH-th error cycle still increments o_err_cnt.
- Timeout counter clears on ILAS entry. Timeout fires when the count reaches ILAS_TIMEOUT-1.
- Reset asserted mid-operation forces every output to its reset value immediately (asynchronous).

## Test plan
- Reset then i_gt_rx_done=1, all lanes K words: o_state 0→1. o_lane_locked=4'hF after 4 K words. o_state=2 and o_nsync=1 on the next cycle.
- CGS with lane 2 sending 3 K words, 1 data word, then K words: lane 2 locks 4 K words later, and ILAS entry is delayed accordingly.
- Full ILAS: 4 multiframes of /R/…/A/ on all lanes, aligned. o_state=3, then o_data equals input delayed 1 cycle with o_data_valid=1.
- ILAS skew: lane 1's 4th /A/ arrives one cycle late. Required: return to CGS with o_nsync=0 and no o_data_valid pulse. Repeat with no /R/ for 1024 cycles: timeout returns to CGS.
- DATA with i_rx_err=1 on lane 0 for 7 cycles, 1 clean cycle, then 8 cycles: o_err_cnt=15. Resync only after the 8-cycle run. o_state=1 the next cycle.
- DATA with a K word injected on lane 3: o_state=1 next cycle. Separately, drop i_gt_rx_done during DATA: o_state=0 next cycle with o_err_cnt retained. Assert i_rst_n=0: all outputs reset immediately.

Source files
------------

// File: rtl/jesd204b_link_ctrl_if.sv
// Purpose: groups the JESD204B receive lane bus and link status of jesd204b_link_ctrl.
// Latency: n/a (signal bundle only).
// Backpressure: none; lane data is a free-running stream from the transceiver.
// Ports: master drives the GT-side inputs (rx_done, byteisaligned, rx_data/k/err) and
//        observes status. slave is the link controller, which drives SYNC~,
//        comma-align enables, state, lock, data/valid and the error count.
interface jesd204b_link_ctrl_if #(
    parameter int LANES = 4
);
    logic                   i_gt_rx_done;
    logic [LANES-1:0]       i_byteisaligned;
    logic [32*LANES-1:0]    i_rx_data;
    logic [4*LANES-1:0]     i_rx_k;
    logic [4*LANES-1:0]     i_rx_err;
    logic                   o_nsync;
    logic [LANES-1:0]       o_commaalignen;
    logic [1:0]             o_state;
    logic [LANES-1:0]       o_lane_locked;
    logic [32*LANES-1:0]    o_data;
    logic                   o_data_valid;
    logic [7:0]             o_err_cnt;

    modport master (
        output i_gt_rx_done, i_byteisaligned, i_rx_data, i_rx_k, i_rx_err,
        input  o_nsync, o_commaalignen, o_state, o_lane_locked, o_data, o_data_valid, o_err_cnt
    );

    modport slave (
        input  i_gt_rx_done, i_byteisaligned, i_rx_data, i_rx_k, i_rx_err,
        output o_nsync, o_commaalignen, o_state, o_lane_locked, o_data, o_data_valid, o_err_cnt
    );
endinterface

// File: rtl/jesd204b_link_ctrl.sv
// Purpose: JESD204B subclass-1 RX link bring-up: WAIT -> CGS -> ILAS -> DATA, with resync.
// Latency: lane words reach o_data one cycle after sampling; status outputs change with o_state.
// Backpressure: none; the ADC stream cannot be stalled, so o_data_valid simply follows DATA.
// Ports: i_clk / i_rst_n (async, active low) plus the slave side of jesd204b_link_ctrl_if.
module jesd204b_link_ctrl #(
    parameter int LANES        = 4,
    parameter int CGS_COUNT    = 4,
    parameter int ILAS_MF      = 4,
    parameter int ILAS_TIMEOUT = 1024,
    parameter int ERR_THRESH   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    jesd204b_link_ctrl_if.slave  lnk
);
    localparam int CW = $clog2(CGS_COUNT + 1);
    localparam int AW = $clog2(ILAS_MF + 1);
    localparam int TW = $clog2(ILAS_TIMEOUT);
    localparam int EW = $clog2(ERR_THRESH + 1);

    localparam logic [CW-1:0] CGS_FULL = CW'(CGS_COUNT);
    localparam logic [AW-1:0] A_LAST   = AW'(ILAS_MF - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ILAS_TIMEOUT - 1);
    localparam logic [EW-1:0] ERR_LAST = EW'(ERR_THRESH - 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t                 state;
    state_t                 nxt;
    logic [CW-1:0]          cgs_cnt [LANES];
    logic [LANES-1:0]       r_seen;
    logic [AW-1:0]          a_cnt [LANES];
    logic [TW-1:0]          tmo_cnt;
    logic [EW-1:0]          err_run;
    logic [7:0]             err_cnt;
    logic                   nsync_q;
    logic [LANES-1:0]       align_q;
    logic [32*LANES-1:0]    data_q;
    logic                   valid_q;

    logic [LANES-1:0]       k_word;
    logic [LANES-1:0]       is_r;
    logic [LANES-1:0]       is_a;
    logic [LANES-1:0]       locked;
    logic [LANES-1:0]       ilas_bad;
    logic [LANES-1:0]       done_now;
    logic [LANES-1:0]       lane_err;
    logic                   err_cycle;
    logic                   skew;

    // Per-lane word classification.
    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            k_word[n]   = (lnk.i_rx_data[32*n +: 32] == 32'hBCBC_BCBC) &&
                          (lnk.i_rx_k[4*n +: 4] == 4'hF) &&
                          (lnk.i_rx_err[4*n +: 4] == 4'h0) &&
                          lnk.i_byteisaligned[n];
            is_r[n]     = (lnk.i_rx_data[32*n +: 8] == 8'h1C) && lnk.i_rx_k[4*n];
            is_a[n]     = (lnk.i_rx_data[32*n+24 +: 8] == 8'h7C) && lnk.i_rx_k[4*n+3];
            locked[n]   = (cgs_cnt[n] == CGS_FULL);
            // Before /R/ only K words or /R/ itself are legal; /R/ in a later octet
            // is not recognised and therefore lands here as an error too.
            ilas_bad[n] = !r_seen[n] && !k_word[n] && !is_r[n];
            done_now[n] = r_seen[n] && is_a[n] && (a_cnt[n] == A_LAST);
            lane_err[n] = (|lnk.i_rx_err[4*n +: 4]) || !lnk.i_byteisaligned[n];
        end
    end

    assign err_cycle = |lane_err;
    // There is no deskew buffer, so lanes finishing ILAS in different cycles is fatal.
    assign skew      = (|done_now) && !(&done_now);

    always_comb begin
        nxt = state;
        if (!lnk.i_gt_rx_done) begin
            nxt = ST_WAIT;
        end else begin
            case (state)
                ST_WAIT: nxt = ST_CGS;
                ST_CGS:  if (&locked) nxt = ST_ILAS;
                ST_ILAS: begin
                    if ((|ilas_bad) || skew)     nxt = ST_CGS;
                    else if (&done_now)          nxt = ST_DATA;
                    else if (tmo_cnt == TMO_LAST) nxt = ST_CGS;
                end
                ST_DATA: begin
                    // Transmitter-initiated resync outranks the error-run limit.
                    if (|k_word)                                 nxt = ST_CGS;
                    else if (err_cycle && (err_run == ERR_LAST)) nxt = ST_CGS;
                end
                default: nxt = ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_WAIT;
            nsync_q <= 1'b0;
            align_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            tmo_cnt <= '0;
            err_run <= '0;
            err_cnt <= '0;
            r_seen  <= '0;
            for (int n = 0; n < LANES; n++) begin
                cgs_cnt[n] <= '0;
                a_cnt[n]   <= '0;
            end
        end else begin
            state <= nxt;

            // Status outputs decoded from the next state so they move with o_state.
            nsync_q <= (nxt == ST_ILAS) || (nxt == ST_DATA);
            align_q <= (nxt == ST_CGS) ? '1 : '0;
            valid_q <= (nxt == ST_DATA);
            if (nxt == ST_DATA) data_q <= lnk.i_rx_data;

            // Lock counters restart on every fresh CGS entry and freeze once CGS is left.
            for (int n = 0; n < LANES; n++) begin
                if ((nxt == ST_WAIT) || ((state != ST_CGS) && (nxt == ST_CGS))) begin
                    cgs_cnt[n] <= '0;
                end else if ((state == ST_CGS) && (nxt == ST_CGS)) begin
                    if (!k_word[n])      cgs_cnt[n] <= '0;
                    else if (!locked[n]) cgs_cnt[n] <= cgs_cnt[n] + 1'b1;
                end
            end

            // ILAS tracking lives only while staying in ILAS; zero otherwise so entry starts clean.
            if ((state == ST_ILAS) && (nxt == ST_ILAS)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                for (int n = 0; n < LANES; n++) begin
                    if (!r_seen[n])  r_seen[n] <= is_r[n];
                    else if (is_a[n]) a_cnt[n] <= a_cnt[n] + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
                r_seen  <= '0;
                for (int n = 0; n < LANES; n++) a_cnt[n] <= '0;
            end

            if ((state == ST_DATA) && err_cycle && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

            if ((state == ST_DATA) && (nxt == ST_DATA) && err_cycle) err_run <= err_run + 1'b1;
            else                                                  err_run <= '0;
        end
    end

    assign lnk.o_state        = state;
    assign lnk.o_nsync        = nsync_q;
    assign lnk.o_commaalignen = align_q;
    assign lnk.o_lane_locked  = locked;
    assign lnk.o_data         = data_q;
    assign lnk.o_data_valid   = valid_q;
    assign lnk.o_err_cnt      = err_cnt;
endmodule

// File: tb/tb_jesd204b_link_ctrl.sv
`timescale 1ns/1ps
module tb_jesd204b_link_ctrl;
    localparam int LANES = 4;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    logic [32*LANES-1:0] sb_q [$];
    logic [32*LANES-1:0] last_cap = '0;

    jesd204b_link_ctrl_if #(.LANES(LANES)) lnk ();

    jesd204b_link_ctrl #(
        .LANES(LANES), .CGS_COUNT(4), .ILAS_MF(4), .ILAS_TIMEOUT(1024), .ERR_THRESH(8)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .lnk     (lnk)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_lane(input int n, input logic [31:0] w, input logic [3:0] k);
        lnk.i_rx_data[32*n +: 32] = w;
        lnk.i_rx_k[4*n +: 4]      = k;
        lnk.i_rx_err[4*n +: 4]    = 4'h0;
        lnk.i_byteisaligned[n]    = 1'b1;
    endtask

    task automatic all_k();
        for (int n = 0; n < LANES; n++) set_lane(n, 32'hBCBC_BCBC, 4'hF);
    endtask

    // First 15 ILAS words: 4 multiframes of /R/, two config words, /A/, minus the last /A/.
    task automatic ilas_prefix();
        for (int i = 0; i < 15; i++) begin
            for (int n = 0; n < LANES; n++) begin
                case (i % 4)
                    0:       set_lane(n, 32'h3322_111C, 4'b0001);
                    3:       set_lane(n, 32'h7C00_0000 | i, 4'b1000);
                    default: set_lane(n, 32'h0A0B_0C00 | i, 4'b0000);
                endcase
            end
            step();
        end
    endtask

    task automatic final_a(input int late);
        for (int n = 0; n < LANES; n++) begin
            if (n == late) set_lane(n, 32'h0A0B_0C0F, 4'b0000);
            else           set_lane(n, 32'h7C00_000F, 4'b1000);
        end
        step();
    endtask

    task automatic go_ilas();
        int cyc;
        lnk.i_gt_rx_done = 1'b1;
        all_k();
        cyc = 0;
        while (lnk.o_state !== 2'd2 && cyc < 30) begin
            step();
            cyc++;
        end
        total++;
        if (lnk.o_state !== 2'd2) begin
            bad++;
            $display("FAIL go_ilas_timeout state=%0d required=2", lnk.o_state);
        end
    endtask

    task automatic go_data();
        go_ilas();
        ilas_prefix();
        final_a(-1);
        total++;
        if (lnk.o_state !== 2'd3) begin bad++; $display("FAIL go_data_state got=%0d exp=3", lnk.o_state); end
    endtask

    // One DATA-state cycle of random lane words; lane 0 error bits from e0.
    task automatic data_cycle(input logic capture, input logic [3:0] e0);
        logic [32*LANES-1:0] w;
        logic [32*LANES-1:0] exp_w;
        for (int n = 0; n < LANES; n++) begin
            w[32*n +: 32] = $urandom;
            set_lane(n, w[32*n +: 32], 4'h0);
        end
        lnk.i_rx_err[3:0] = e0;
        if (capture) begin
            sb_q.push_back(w);
            last_cap = w;
        end
        step();
        total++;
        if (lnk.o_data_valid !== capture) begin
            bad++;
            $display("FAIL data_valid got=%b exp=%b", lnk.o_data_valid, capture);
        end
        if (lnk.o_data_valid === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow got=%h exp=<none>", lnk.o_data);
            end else begin
                exp_w = sb_q.pop_front();
                if (lnk.o_data !== exp_w) begin
                    bad++;
                    $display("FAIL sb_data got=%h exp=%h", lnk.o_data, exp_w);
                end
            end
        end
    endtask

    task automatic test_reset();
        lnk.i_gt_rx_done    = 1'b0;
        lnk.i_byteisaligned = '0;
        lnk.i_rx_data       = '0;
        lnk.i_rx_k          = '0;
        lnk.i_rx_err        = '0;
        #2 i_rst_n = 1'b0;
        step();
        step();
        total++; if (lnk.o_state !== 2'd0)        begin bad++; $display("FAIL rst_state got=%0d exp=0", lnk.o_state); end
        total++; if (lnk.o_nsync !== 1'b0)        begin bad++; $display("FAIL rst_nsync got=%b exp=0", lnk.o_nsync); end
        total++; if (lnk.o_commaalignen !== 4'h0) begin bad++; $display("FAIL rst_align got=%h exp=0", lnk.o_commaalignen); end
        total++; if (lnk.o_lane_locked !== 4'h0)  begin bad++; $display("FAIL rst_locked got=%h exp=0", lnk.o_lane_locked); end
        total++; if (lnk.o_data !== '0)           begin bad++; $display("FAIL rst_data got=%h exp=0", lnk.o_data); end
        total++; if (lnk.o_data_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid got=%b exp=0", lnk.o_data_valid); end
        total++; if (lnk.o_err_cnt !== 8'd0)      begin bad++; $display("FAIL rst_errcnt got=%0d exp=0", lnk.o_err_cnt); end
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_cgs_lock();
        all_k();
        lnk.i_gt_rx_done = 1'b1;
        step();
        total++; if (lnk.o_state !== 2'd1)        begin bad++; $display("FAIL cgs_entry got=%0d exp=1", lnk.o_state); end
        total++; if (lnk.o_commaalignen !== 4'hF) begin bad++; $display("FAIL cgs_align got=%h exp=f", lnk.o_commaalignen); end
        total++; if (lnk.o_nsync !== 1'b0)        begin bad++; $display("FAIL cgs_nsync got=%b exp=0", lnk.o_nsync); end
        repeat (3) step();
        total++; if (lnk.o_lane_locked !== 4'h0)  begin bad++; $display("FAIL cgs_lock3 got=%h exp=0", lnk.o_lane_locked); end
        step();
        total++; if (lnk.o_lane_locked !== 4'hF)  begin bad++; $display("FAIL cgs_lock4 got=%h exp=f", lnk.o_lane_locked); end
        total++; if (lnk.o_state !== 2'd1)        begin bad++; $display("FAIL cgs_hold got=%0d exp=1", lnk.o_state); end
        step();
        total++; if (lnk.o_state !== 2'd2)        begin bad++; $display("FAIL ilas_entry got=%0d exp=2", lnk.o_state); end
        total++; if (lnk.o_nsync !== 1'b1)        begin bad++; $display("FAIL ilas_nsync got=%b exp=1", lnk.o_nsync); end
        total++; if (lnk.o_commaalignen !== 4'h0) begin bad++; $display("FAIL ilas_align got=%h exp=0", lnk.o_commaalignen); end
    endtask

    task automatic test_cgs_glitch();
        lnk.i_gt_rx_done = 1'b0;
        step();
        total++; if (lnk.o_state !== 2'd0) begin bad++; $display("FAIL drop_wait got=%0d exp=0", lnk.o_state); end
        lnk.i_gt_rx_done = 1'b1;
        all_k();
        step();
        repeat (3) step();
        set_lane(2, 32'h1234_5678, 4'h0);
        step();
        all_k();
        repeat (3) step();
        total++; if (lnk.o_lane_locked !== 4'b1011) begin bad++; $display("FAIL glitch_lock got=%b exp=1011", lnk.o_lane_locked); end
        total++; if (lnk.o_state !== 2'd1)          begin bad++; $display("FAIL glitch_hold got=%0d exp=1", lnk.o_state); end
        step();
        total++; if (lnk.o_lane_locked !== 4'hF)    begin bad++; $display("FAIL glitch_lock4 got=%h exp=f", lnk.o_lane_locked); end
        step();
        total++; if (lnk.o_state !== 2'd2)          begin bad++; $display("FAIL glitch_ilas got=%0d exp=2", lnk.o_state); end
    endtask

    task automatic test_ilas_full();
        ilas_prefix();
        total++; if (lnk.o_state !== 2'd2) begin bad++; $display("FAIL ilas_before_last got=%0d exp=2", lnk.o_state); end
        final_a(-1);
        total++; if (lnk.o_state !== 2'd3) begin bad++; $display("FAIL data_entry got=%0d exp=3", lnk.o_state); end
        total++; if (lnk.o_data_valid !== 1'b1) begin bad++; $display("FAIL data_entry_valid got=%b exp=1", lnk.o_data_valid); end
        repeat (10) data_cycle(1'b1, 4'h0);
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_left got=%0d exp=0", sb_q.size()); end
    endtask

    task automatic test_data_errors();
        repeat (7) data_cycle(1'b1, 4'h1);
        total++; if (lnk.o_err_cnt !== 8'd7) begin bad++; $display("FAIL err7 got=%0d exp=7", lnk.o_err_cnt); end
        data_cycle(1'b1, 4'h0);
        repeat (7) data_cycle(1'b1, 4'h1);
        total++; if (lnk.o_state !== 2'd3)    begin bad++; $display("FAIL err_run7_state got=%0d exp=3", lnk.o_state); end
        data_cycle(1'b0, 4'h1);
        total++; if (lnk.o_state !== 2'd1)    begin bad++; $display("FAIL err_resync got=%0d exp=1", lnk.o_state); end
        total++; if (lnk.o_err_cnt !== 8'd15) begin bad++; $display("FAIL err15 got=%0d exp=15", lnk.o_err_cnt); end
        total++; if (sb_q.size() != 0)        begin bad++; $display("FAIL sb_left_err got=%0d exp=0", sb_q.size()); end
    endtask

    task automatic test_ilas_skew();
        go_ilas();
        ilas_prefix();
        final_a(1);
        total++; if (lnk.o_state !== 2'd1)      begin bad++; $display("FAIL skew_state got=%0d exp=1", lnk.o_state); end
        total++; if (lnk.o_nsync !== 1'b0)      begin bad++; $display("FAIL skew_nsync got=%b exp=0", lnk.o_nsync); end
        total++; if (lnk.o_data_valid !== 1'b0) begin bad++; $display("FAIL skew_valid got=%b exp=0", lnk.o_data_valid); end
    endtask

    task automatic test_ilas_timeout();
        go_ilas();
        all_k();
        repeat (1023) step();
        total++; if (lnk.o_state !== 2'd2) begin bad++; $display("FAIL tmo_early got=%0d exp=2", lnk.o_state); end
        step();
        total++; if (lnk.o_state !== 2'd1) begin bad++; $display("FAIL tmo_state got=%0d exp=1", lnk.o_state); end
        total++; if (lnk.o_nsync !== 1'b0) begin bad++; $display("FAIL tmo_nsync got=%b exp=0", lnk.o_nsync); end
    endtask

    task automatic test_resync_k();
        go_data();
        repeat (3) data_cycle(1'b1, 4'h0);
        for (int n = 0; n < 3; n++) set_lane(n, $urandom, 4'h0);
        set_lane(3, 32'hBCBC_BCBC, 4'hF);
        step();
        total++; if (lnk.o_state !== 2'd1)      begin bad++; $display("FAIL kres_state got=%0d exp=1", lnk.o_state); end
        total++; if (lnk.o_data_valid !== 1'b0) begin bad++; $display("FAIL kres_valid got=%b exp=0", lnk.o_data_valid); end
        total++; if (lnk.o_data !== last_cap)   begin bad++; $display("FAIL kres_hold got=%h exp=%h", lnk.o_data, last_cap); end
        total++; if (lnk.o_err_cnt !== 8'd15)   begin bad++; $display("FAIL kres_errcnt got=%0d exp=15", lnk.o_err_cnt); end
    endtask

    task automatic test_drop_done();
        go_data();
        data_cycle(1'b1, 4'h1);
        total++; if (lnk.o_err_cnt !== 8'd16) begin bad++; $display("FAIL drop_pre_err got=%0d exp=16", lnk.o_err_cnt); end
        for (int n = 0; n < LANES; n++) set_lane(n, $urandom, 4'h0);
        lnk.i_gt_rx_done = 1'b0;
        step();
        total++; if (lnk.o_state !== 2'd0)      begin bad++; $display("FAIL drop_state got=%0d exp=0", lnk.o_state); end
        total++; if (lnk.o_err_cnt !== 8'd16)   begin bad++; $display("FAIL drop_errcnt got=%0d exp=16", lnk.o_err_cnt); end
        total++; if (lnk.o_data_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b exp=0", lnk.o_data_valid); end
        total++; if (lnk.o_nsync !== 1'b0)      begin bad++; $display("FAIL drop_nsync got=%b exp=0", lnk.o_nsync); end
        total++; if (sb_q.size() != 0)          begin bad++; $display("FAIL sb_left_drop got=%0d exp=0", sb_q.size()); end
    endtask

    task automatic test_async_reset();
        lnk.i_gt_rx_done = 1'b1;
        all_k();
        repeat (5) step();
        total++; if (lnk.o_lane_locked !== 4'hF) begin bad++; $display("FAIL arst_pre_lock got=%h exp=f", lnk.o_lane_locked); end
        #3 i_rst_n = 1'b0;
        #1;
        total++; if (lnk.o_state !== 2'd0)        begin bad++; $display("FAIL arst_state got=%0d exp=0", lnk.o_state); end
        total++; if (lnk.o_nsync !== 1'b0)        begin bad++; $display("FAIL arst_nsync got=%b exp=0", lnk.o_nsync); end
        total++; if (lnk.o_commaalignen !== 4'h0) begin bad++; $display("FAIL arst_align got=%h exp=0", lnk.o_commaalignen); end
        total++; if (lnk.o_lane_locked !== 4'h0)  begin bad++; $display("FAIL arst_locked got=%h exp=0", lnk.o_lane_locked); end
        total++; if (lnk.o_data !== '0)           begin bad++; $display("FAIL arst_data got=%h exp=0", lnk.o_data); end
        total++; if (lnk.o_data_valid !== 1'b0)   begin bad++; $display("FAIL arst_valid got=%b exp=0", lnk.o_data_valid); end
        total++; if (lnk.o_err_cnt !== 8'd0)      begin bad++; $display("FAIL arst_errcnt got=%0d exp=0", lnk.o_err_cnt); end
        step();
        i_rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_cgs_lock();
        test_cgs_glitch();
        test_ilas_full();
        test_data_errors();
        test_ilas_skew();
        test_ilas_timeout();
        test_resync_k();
        test_drop_done();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
